ps2_key_event_rx: RTL and testbench
===================================

PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- FILTER_LEN, 8: consecutive equal CLK samples before a filtered PS/2 line changes.
- TIMEOUT_CYC, 1000000: CLK cycles without a PS2_CLK falling edge before a partial frame is discarded.

REQ-002 Ports, one per line: name  direction  width  meaning.
- CLK  in  1  board clock; one clock, all logic on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- PS2_CLK  in  1  keyboard clock, asynchronous.
- PS2_DATA  in  1  keyboard data, asynchronous.
- KEY_VALID  out  1  one-cycle event strobe.
- KEY_CODE  out  8  scan code of the event.
- KEY_EXT  out  1  event was preceded by 8'hE0.
- KEY_RELEASE  out  1  event was preceded by 8'hF0 (break).
- FRAME_ERR  out  1  one-cycle strobe on a rejected frame.

REQ-003 KEY_CODE, KEY_EXT and KEY_RELEASE SHALL be stable while KEY_VALID=1 and hold their value until the next event.

Function
REQ-004 Each PS/2 line SHALL be 2-flop synchronised and then glitch-filtered: it changes only after FILTER_LEN consecutive identical samples.
REQ-005 A falling edge SHALL be detected as filtered PS2_CLK going 1->0; filtered PS2_DATA SHALL be sampled in that same cycle.
REQ-006 FSM states SHALL be IDLE, RECV and CHECK.
- IDLE->RECV on a falling edge with data=0 (start bit).
- An edge in IDLE with data=1 SHALL be ignored.
REQ-007 RECV SHALL shift 10 further bits LSB first (8 data bits, parity, stop), then go to CHECK.
REQ-008 CHECK SHALL last exactly one cycle and accept the frame only when stop=1 and the data bits plus the parity bit contain an odd number of ones.
- A rejected frame SHALL pulse FRAME_ERR and return to IDLE.
REQ-009 An accepted 8'hE0 SHALL set the ext flag; an accepted 8'hF0 SHALL set the release flag; neither SHALL produce KEY_VALID.
REQ-010 Any other accepted code SHALL drive the outputs and pulse KEY_VALID in the cycle after CHECK, then clear both flags.
- Latency: 2 CLK cycles after the stop-bit edge is detected.
REQ-011 A timeout counter SHALL run in RECV and restart on every falling edge.
- When it reaches TIMEOUT_CYC-1: discard the frame, pulse FRAME_ERR, clear both flags, go to IDLE.
REQ-012 FRAME_ERR SHALL also clear both prefix flags.
REQ-013 A falling edge that arrives in the CHECK cycle SHALL be ignored; a valid PS/2 bit period always exceeds 2 cycles.

Reset
REQ-014 While RST_N=0, all outputs SHALL be 0, KEY_CODE SHALL be 8'h00, the FSM SHALL be IDLE, the flags and counters SHALL be 0, and the filtered lines SHALL be 1.
REQ-015 Reset asserted mid-frame SHALL discard the partial frame with no KEY_VALID and no FRAME_ERR.

Configuration
REQ-016 With PS2_RX_TYPEMATIC_FILTER_EN defined:
- Store the last make {ext,code}.
- A make identical to the stored value SHALL be suppressed, with no KEY_VALID.
- A break with the same {ext,code} SHALL clear the stored value and be emitted.
- Reset SHALL clear the stored value.
REQ-017 Without PS2_RX_TYPEMATIC_FILTER_EN, every make SHALL be emitted, and no storage for the last make SHALL exist.

Structure
REQ-018 Package ps2_pkg SHALL hold the FSM state enum, PS2_EXT=8'hE0, PS2_BREAK=8'hF0, and the arrow codes 8'h6B (left), 8'h74 (right), 8'h75 (up) and 8'h72 (down).
REQ-019 Sub-module ps2_line_filter (synchroniser plus glitch filter) SHALL be instantiated once per PS/2 line.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Frame 8'h6B, parity 0, stop 1 -> one KEY_VALID; KEY_CODE=6B, KEY_EXT=0, KEY_RELEASE=0.
- Frames E0, F0, 74 -> exactly one KEY_VALID; KEY_CODE=74, KEY_EXT=1, KEY_RELEASE=1.
- Frame 8'h74 with parity flipped -> FRAME_ERR pulse, no KEY_VALID; the next frame 6B decodes with KEY_EXT=0.
- 5 bits, then idle for TIMEOUT_CYC cycles -> FRAME_ERR; a following 6B frame decodes correctly.
- PS2_CLK low glitch of FILTER_LEN-1 cycles inside a frame -> no extra bit shifted, frame decodes correctly.
- Frames 6B, 6B, 6B, F0, 6B -> with the macro defined, 2 KEY_VALIDs (make, break); without it, 4 KEY_VALIDs.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key event receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_RIGHT = 8'h74;
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output follows the input only after
// FILTER_LEN consecutive samples that differ from the current output.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_line
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_line = r_filt;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into flags, emits key events.
// Optional macro PS2_RX_TYPEMATIC_FILTER_EN suppresses repeated makes of the same key.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       KEY_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_RELEASE,
    output logic       FRAME_ERR
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_frame_ok;

    ps2_state_e r_state, w_state_d;
    logic          r_clk_prev;
    logic [9:0]    r_shift, w_shift_d;
    logic [3:0]    r_bit_cnt, w_bit_cnt_d;
    logic [TW-1:0] r_tmo, w_tmo_d;
    logic          r_ext, w_ext_d;
    logic          r_rel, w_rel_d;
    logic          r_valid, w_valid_d;
    logic          r_err, w_err_d;
    logic [7:0]    r_code, w_code_d;
    logic          r_key_ext, w_key_ext_d;
    logic          r_key_rel, w_key_rel_d;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    logic          r_last_vld, w_last_vld_d;
    logic [8:0]    r_last, w_last_d;
    logic          w_match;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_line  (PS2_CLK),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_line  (PS2_DATA),
        .o_line  (w_data_f)
    );

    assign w_fall     = r_clk_prev & ~w_clk_f;
    // shift[7:0] data, shift[8] parity, shift[9] stop
    assign w_frame_ok = r_shift[9] & (^r_shift[8:0]);
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    assign w_match    = r_last_vld && (r_last == {r_ext, r_shift[7:0]});
`endif

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_bit_cnt_d  = r_bit_cnt;
        w_tmo_d      = r_tmo;
        w_ext_d      = r_ext;
        w_rel_d      = r_rel;
        w_valid_d    = 1'b0;
        w_err_d      = 1'b0;
        w_code_d     = r_code;
        w_key_ext_d  = r_key_ext;
        w_key_rel_d  = r_key_rel;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
        w_last_vld_d = r_last_vld;
        w_last_d     = r_last;
`endif
        unique case (r_state)
            IDLE: begin
                w_tmo_d = '0;
                if (w_fall && !w_data_f) begin
                    w_state_d   = RECV;
                    w_bit_cnt_d = '0;
                end
            end
            RECV: begin
                if (w_fall) begin
                    w_shift_d   = {w_data_f, r_shift[9:1]};
                    w_bit_cnt_d = r_bit_cnt + 4'd1;
                    w_tmo_d     = '0;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_d = CHECK;
                    end
                end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                    w_state_d = IDLE;
                    w_tmo_d   = '0;
                    w_err_d   = 1'b1;
                    w_ext_d   = 1'b0;
                    w_rel_d   = 1'b0;
                end else begin
                    w_tmo_d = r_tmo + 1'b1;
                end
            end
            CHECK: begin
                w_state_d = IDLE;
                if (!w_frame_ok) begin
                    w_err_d = 1'b1;
                    w_ext_d = 1'b0;
                    w_rel_d = 1'b0;
                end else if (r_shift[7:0] == PS2_EXT) begin
                    w_ext_d = 1'b1;
                end else if (r_shift[7:0] == PS2_BREAK) begin
                    w_rel_d = 1'b1;
                end else begin
                    w_ext_d = 1'b0;
                    w_rel_d = 1'b0;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
                    // A make equal to the held key is an auto-repeat and is dropped.
                    if (r_rel || !w_match) begin
                        w_valid_d   = 1'b1;
                        w_code_d    = r_shift[7:0];
                        w_key_ext_d = r_ext;
                        w_key_rel_d = r_rel;
                    end
                    if (!r_rel) begin
                        w_last_vld_d = 1'b1;
                        w_last_d     = {r_ext, r_shift[7:0]};
                    end else if (w_match) begin
                        w_last_vld_d = 1'b0;
                    end
`else
                    w_valid_d   = 1'b1;
                    w_code_d    = r_shift[7:0];
                    w_key_ext_d = r_ext;
                    w_key_rel_d = r_rel;
`endif
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_clk_prev <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tmo      <= '0;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= 8'h00;
            r_key_ext  <= 1'b0;
            r_key_rel  <= 1'b0;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
            r_last_vld <= 1'b0;
            r_last     <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_clk_prev <= w_clk_f;
            r_shift    <= w_shift_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_tmo      <= w_tmo_d;
            r_ext      <= w_ext_d;
            r_rel      <= w_rel_d;
            r_valid    <= w_valid_d;
            r_err      <= w_err_d;
            r_code     <= w_code_d;
            r_key_ext  <= w_key_ext_d;
            r_key_rel  <= w_key_rel_d;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
            r_last_vld <= w_last_vld_d;
            r_last     <= w_last_d;
`endif
        end
    end

    assign KEY_VALID   = r_valid;
    assign KEY_CODE    = r_code;
    assign KEY_EXT     = r_key_ext;
    assign KEY_RELEASE = r_key_rel;
    assign FRAME_ERR   = r_err;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: expected events are queued as frames are sent and a
// monitor compares them against KEY_VALID / FRAME_ERR strobes.
module tb_ps2_key_event_rx;

    localparam int unsigned FL  = 4;
    localparam int unsigned TMO = 500;
    localparam int unsigned H   = 20;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       KEY_VALID;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_RELEASE;
    logic       FRAME_ERR;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    ps2_key_event_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .KEY_VALID   (KEY_VALID),
        .KEY_CODE    (KEY_CODE),
        .KEY_EXT     (KEY_EXT),
        .KEY_RELEASE (KEY_RELEASE),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic ev_t key(input logic [7:0] c, input logic e, input logic r);
        ev_t v;
        v.err = 1'b0; v.code = c; v.ext = e; v.rel = r;
        return v;
    endfunction

    function automatic ev_t err_ev();
        ev_t v;
        v = '0;
        v.err = 1'b1;
        return v;
    endfunction

    // Sends the first n bits of a frame; a sub-filter-length clock glitch follows bit glitch_at.
    task automatic send_bits(input logic [7:0] code, input logic bad_par, input int n,
                             input int glitch_at);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < n; i++) begin
            PS2_DATA = bits[i];
            cyc(H);
            PS2_CLK = 1'b0;
            cyc(H);
            PS2_CLK = 1'b1;
            if (i == glitch_at) begin
                cyc(5);
                PS2_CLK = 1'b0;
                cyc(FL - 1);
                PS2_CLK = 1'b1;
            end
        end
        PS2_DATA = 1'b1;
        cyc(H);
    endtask

    task automatic send(input logic [7:0] code);
        send_bits(code, 1'b0, 11, -1);
    endtask

    task automatic check_event();
        ev_t act, exp;
        act = FRAME_ERR ? err_ev() : key(KEY_CODE, KEY_EXT, KEY_RELEASE);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got err=%0b code=%h ext=%0b rel=%0b, required none",
                     act.err, act.code, act.ext, act.rel);
        end else begin
            exp = q.pop_front();
            if (act !== exp || (KEY_VALID && FRAME_ERR)) begin
                n_fail++;
                $display("FAIL event: got err=%0b code=%h ext=%0b rel=%0b, required err=%0b code=%h ext=%0b rel=%0b",
                         act.err, act.code, act.ext, act.rel, exp.err, exp.code, exp.ext, exp.rel);
            end
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        while (q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if ({KEY_VALID, KEY_CODE, KEY_EXT, KEY_RELEASE, FRAME_ERR} !== 12'h000) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b code=%h ext=%0b rel=%0b err=%0b, required all 0",
                     name, KEY_VALID, KEY_CODE, KEY_EXT, KEY_RELEASE, FRAME_ERR);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (RST_N === 1'b1 && (KEY_VALID === 1'b1 || FRAME_ERR === 1'b1)) check_event();
            end
        join_none

        cyc(3);
        check_reset_outputs("reset_state");
        RST_N = 1'b1;
        cyc(30);

        q.push_back(key(8'h6B, 1'b0, 1'b0));
        send(8'h6B);
        drain("make_6b");

        q.push_back(key(8'h74, 1'b1, 1'b1));
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        drain("ext_break_74");

        q.push_back(err_ev());
        send_bits(8'h74, 1'b1, 11, -1);
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        send(8'h6B);
        drain("parity_err");

        // E0 prefix followed by a bad frame: the error must clear the ext flag.
        send(8'hE0);
        q.push_back(err_ev());
        send_bits(8'h72, 1'b1, 11, -1);
        q.push_back(key(8'h72, 1'b0, 1'b0));
        send(8'h72);
        drain("err_clears_flag");

        q.push_back(err_ev());
        send_bits(8'h6B, 1'b0, 5, -1);
        cyc(TMO + 50);
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        send(8'h6B);
        drain("timeout");

        q.push_back(key(8'h75, 1'b0, 1'b0));
        send_bits(8'h75, 1'b0, 11, 4);
        drain("clk_glitch");

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        q.push_back(key(8'h6B, 1'b0, 1'b1));
`else
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        q.push_back(key(8'h6B, 1'b0, 1'b0));
        q.push_back(key(8'h6B, 1'b0, 1'b1));
`endif
        send(8'h6B);
        send(8'h6B);
        send(8'h6B);
        send(8'hF0);
        send(8'h6B);
        drain("typematic");

        // A make stored before reset must be emitted again after reset.
        q.push_back(key(8'h74, 1'b0, 1'b0));
        send(8'h74);
        drain("pre_reset_make");
        send(8'hE0);
        send_bits(8'h6B, 1'b0, 6, -1);
        RST_N = 1'b0;
        cyc(5);
        check_reset_outputs("mid_frame_reset");
        RST_N = 1'b1;
        cyc(TMO + 50);
        q.push_back(key(8'h74, 1'b0, 1'b0));
        send(8'h74);
        drain("post_reset_make");

        cyc(50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
